spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
- Command/register-access controller that sits between the SPI slave (mosi_valid/mosi_word/miso_word_in/miso_accepted) and a flat register file.
- Decodes the first received word of each frame as {rw, addr}, then sequences burst writes or prefetched burst reads with address auto-increment.
- Tracks frame boundaries from its own synchronized copy of ssel and supplies every outgoing MISO word.

Parameters:
WordWidth, 8, bits per SPI word; must match the SPI slave.
AddrWidth, 7, register address width; must be <= WordWidth-1.
SyncStages, 2, synchronizer stages on ssel; must match the SPI slave.
SPOL, 0, ssel polarity; 0 = active low.
StatusWord, 8'hA4, frame-0 MISO word; bit0 is replaced by the wrote flag.
DummyWord, 8'h00, MISO word for the read turnaround slot and for all write-frame data slots.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ssel  in  1  raw SPI slave select (same pin as the SPI slave)
mosi_valid  in  1  one-clk pulse from SPI slave: mosi_word valid
mosi_word  in  WordWidth  received word
miso_accepted  in  1  one-clk pulse: SPI slave latched miso_word_in
miso_word_in  out  WordWidth  next word for the SPI slave to shift out
reg_addr  out  AddrWidth  register address
reg_wr_en  out  1  one-clk write strobe
reg_wdata  out  WordWidth  write data
reg_rd_en  out  1  one-clk read strobe; reg_rdata valid on the following clk
reg_rdata  in  WordWidth  read data
frame_done  out  1  one-clk pulse at frame end (ssel deasserted after a command word)
busy  out  1  high while a frame is active

Behaviour:
- Reset (async, reset_n=0): state IDLE; reg_addr=0; reg_wr_en=0; reg_rd_en=0; reg_wdata=0; frame_done=0; busy=0; wrote flag=0; miso_word_in={StatusWord[W-1:1],1'b0}.
- ssel is normalized to active high (ssel==SPOL) and passed through a SyncStages synchronizer to give sel.
- States:
  - IDLE: miso_word_in = status word. On sel rise -> CMD, busy=1.
  - CMD: the first miso_accepted loads miso_word_in <= DummyWord. On mosi_valid: addr <= mosi_word[AddrWidth-1:0]. If mosi_word[W-1]=0 -> WR. If it is 1 -> RD and issue reg_rd_en at addr on the next clk.
  - WR: each mosi_valid -> next clk reg_wr_en=1, reg_wdata=mosi_word, reg_addr=addr; then addr++ and wrote flag set. miso_word_in stays DummyWord.
  - RD: the read launched on CMD exit captures reg_rdata into miso_word_in one clk after reg_rd_en. Each subsequent miso_accepted -> addr++, reg_rd_en at the new addr, capture the next clk. MOSI words are ignored.
- Resulting MISO sequence for a read frame: status, DummyWord, reg[a], reg[a+1], ...
- The last prefetch in a read frame may touch one address beyond the final word read. The register file must have side-effect-free reads.
- Address arithmetic is modulo 2^AddrWidth: 2^AddrWidth-1 wraps to 0. Bits of mosi_word[W-2:AddrWidth] are ignored.
- sel fall in any non-IDLE state -> IDLE in the next clk:
  - frame_done pulses if the state was WR or RD.
  - An in-flight read capture is discarded.
  - A write already decoded from a completed word still issues.
  - wrote flag <= (writes issued this frame > 0).
  - miso_word_in reloads the status word.
- Simultaneous mosi_valid and miso_accepted in the same clk: both are processed; WR write and RD prefetch are independent.
- A sel fall in the same clk as mosi_valid: the word is processed (write issued), then IDLE.
- Throughput: at most one reg_wr_en or reg_rd_en per clk. The SPI slave guarantees ≥ WordWidth·N clk between words, so no backpressure is needed.
- reset_n assertion mid-frame: immediate return to reset values. The remainder of the SPI frame is ignored until sel falls and rises again; IDLE waits for a fresh rise, not a level.

Decomposition:
- Shared package: state encoding (IDLE, CMD, WR, RD) and the RW bit index constant (WordWidth-1).
- Sub-module: reuse the existing synchronizer (Width=1, Stages=SyncStages) for ssel. No other sub-modules.

Test Plan:
- Write burst: frame {8'h05, 8'h11, 8'h22} -> reg_wr_en at addr 5 with data 11h, then addr 6 with data 22h; frame_done=1; next frame's first MISO word = 8'hA5.
- Read burst: reg[0x10]=3Ch, reg[0x11]=C3h; frame {8'h90, x, x, x} -> MISO A4h/A5h, 00h, 3Ch, C3h.
- Wrap: write frame {8'h7F, AAh, BBh} -> writes addr 7Fh then 00h; read frame from 7Fh returns reg[7F], reg[00].
- Abort: ssel deasserted after 4 bits of word 2 of a write -> exactly one write issued, frame_done pulses, state IDLE, miso_word_in = status.
- Command-only / empty frames: frame {8'h85} -> no writes, frame_done=1. Frame with ssel asserted but no word completed -> no frame_done.
- Reset mid-frame: reset_n low during RD -> all outputs at reset values asynchronously; no further reg_rd_en until a new ssel assertion.

Source files
------------

// File: rtl/spi_reg_ctrl_pkg.sv
// rtl/spi_reg_ctrl_pkg.sv - shared state encoding and command-word helpers for spi_reg_ctrl
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  // The read/write flag is the MSB of the command word
  function automatic int rw_bit_idx(input int word_width);
    return word_width - 1;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_sync.sv
// rtl/spi_reg_ctrl_sync.sv - multi-stage flop synchronizer with configurable reset value
module spi_reg_ctrl_sync #(
  parameter int                Width    = 1,
  parameter int                Stages   = 2,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Stages];

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Stages; i++) stage_q[i] <= ResetVal;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[Stages-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command decoder sequencing burst register writes and prefetched reads
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int                   WordWidth  = 8,
  parameter int                   AddrWidth  = 7,
  parameter int                   SyncStages = 2,
  parameter bit                   SPOL       = 1'b0,
  parameter logic [WordWidth-1:0] StatusWord = 8'hA4,
  parameter logic [WordWidth-1:0] DummyWord  = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ssel,
  input  logic                 mosi_valid,
  input  logic [WordWidth-1:0] mosi_word,
  input  logic                 miso_accepted,
  output logic [WordWidth-1:0] miso_word_in,
  output logic [AddrWidth-1:0] reg_addr,
  output logic                 reg_wr_en,
  output logic [WordWidth-1:0] reg_wdata,
  output logic                 reg_rd_en,
  input  logic [WordWidth-1:0] reg_rdata,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int RwBit = rw_bit_idx(WordWidth);

  state_t               state, next_state;
  logic                 sel_raw, sel, sel_d;
  logic                 sel_rise, sel_fall, frame_end;
  logic                 write_now;
  logic                 wrote, rd_capture;
  logic [AddrWidth-1:0] addr, addr_inc, mosi_addr;

  function automatic logic [WordWidth-1:0] status_word(input logic w);
    return {StatusWord[WordWidth-1:1], w};
  endfunction

  assign sel_raw = (ssel == SPOL);

  // Synchronizer resets high so a frame in progress at reset release never looks like a new rise
  spi_reg_ctrl_sync #(
    .Width    (1),
    .Stages   (SyncStages),
    .ResetVal (1'b1)
  ) u_sel_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sel_raw),
    .q       (sel)
  );

  // Delayed copy of sel for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sel_d <= 1'b1;
    else          sel_d <= sel;
  end

  assign sel_rise  = sel & ~sel_d;
  assign sel_fall  = ~sel & sel_d;
  assign frame_end = sel_fall && (state != ST_IDLE);
  assign write_now = (state == ST_WR) && mosi_valid;
  assign mosi_addr = mosi_word[AddrWidth-1:0];
  assign addr_inc  = addr + AddrWidth'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state decode; a frame end overrides everything
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (sel_rise) next_state = ST_CMD;
      ST_CMD:  if (mosi_valid) next_state = mosi_word[RwBit] ? ST_RD : ST_WR;
      default: next_state = state;
    endcase
    if (frame_end) next_state = ST_IDLE;
  end

  // Register strobes, address pointer, MISO word and the wrote flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr         <= '0;
      reg_addr     <= '0;
      reg_wr_en    <= 1'b0;
      reg_wdata    <= '0;
      reg_rd_en    <= 1'b0;
      rd_capture   <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      wrote        <= 1'b0;
      miso_word_in <= status_word(1'b0);
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      rd_capture <= 1'b0;
      frame_done <= 1'b0;
      busy       <= (next_state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          miso_word_in <= status_word(wrote);
          if (sel_rise) wrote <= 1'b0;
        end
        ST_CMD: begin
          if (miso_accepted) miso_word_in <= DummyWord;
          if (mosi_valid) begin
            addr <= mosi_addr;
            if (mosi_word[RwBit] && !frame_end) begin
              reg_rd_en <= 1'b1;
              reg_addr  <= mosi_addr;
            end
          end
        end
        ST_WR: begin
          if (mosi_valid) begin
            reg_wr_en <= 1'b1;
            reg_wdata <= mosi_word;
            reg_addr  <= addr;
            addr      <= addr_inc;
            wrote     <= 1'b1;
          end
        end
        ST_RD: begin
          rd_capture <= reg_rd_en;
          if (rd_capture) miso_word_in <= reg_rdata;
          if (miso_accepted && !frame_end) begin
            addr      <= addr_inc;
            reg_addr  <= addr_inc;
            reg_rd_en <= 1'b1;
          end
        end
        default: ;
      endcase
      if (frame_end) begin
        miso_word_in <= status_word(wrote | write_now);
        wrote        <= wrote | write_now;
        rd_capture   <= 1'b0;
        frame_done   <= (state == ST_WR) || (state == ST_RD) ||
                        ((state == ST_CMD) && mosi_valid);
      end
    end
  end

endmodule
